// File: rtl/ms_pkg.sv
// ============================================================================
// ms_pkg : shared state encodings and width helper for the ms tick controller
// Rev 1.0
// ============================================================================
`default_nettype none

package ms_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : two-flop synchronizer, stable-level debounce, press pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_debounce
  import ms_pkg::*;
#(
  parameter int DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int              CNT_W   = clog2w(DEB_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

  logic             s1_q, s2_q;
  logic             deb_q, deb_d;
  logic             deb_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A new level is accepted only after DEB_CYC consecutive disagreeing samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  assign press = deb_q & ~deb_dly_q;

endmodule

`default_nettype wire

// File: rtl/ms_tick_ctrl.sv
// ============================================================================
// ms_tick_ctrl : button control FSM and 1 ms tick prescaler for the counter chain
// Rev 1.0
// ============================================================================
`default_nettype none

module ms_tick_ctrl
  import ms_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1000,
  parameter int DEB_CYC = 1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_SS,
  input  logic       BTN_CLR,
  output logic       TICK,
  output logic       CLR,
  output logic       RUNNING,
  output logic [1:0] STATE
);

  localparam int               DIV      = CLK_HZ / TICK_HZ;
  localparam int               CNT_W    = clog2w(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  generate
    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
      $error("ms_tick_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (DEB_CYC < 2) begin : g_bad_deb
      $error("ms_tick_ctrl: DEB_CYC must be >= 2");
    end
  endgenerate

  logic ss_press, clr_press;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ss (
    .clk     (CLK),
    .rst_n   (RST_N),
    .btn_raw (BTN_SS),
    .press   (ss_press)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clr (
    .clk     (CLK),
    .rst_n   (RST_N),
    .btn_raw (BTN_CLR),
    .press   (clr_press)
  );

  logic [1:0]       state_q, state_d;
  logic             running_q, running_d;
  logic             tick_q, tick_d;
  logic             clr_q, clr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Clear outranks start/stop; the prescaler advances on the pre-edge state.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    tick_d  = 1'b0;
    count_d = count_q;
    if (clr_press) begin
      state_d = ST_IDLE;
      clr_d   = 1'b1;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:  if (ss_press) state_d = ST_RUN;
        ST_RUN:   if (ss_press) state_d = ST_PAUSE;
        ST_PAUSE: if (ss_press) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
      if (state_q == ST_RUN) begin
        if (count_q == CNT_LAST) begin
          count_d = '0;
          tick_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      clr_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      clr_q     <= clr_d;
      count_q   <= count_d;
    end
  end

  assign STATE   = state_q;
  assign RUNNING = running_q;
  assign TICK    = tick_q;
  assign CLR     = clr_q;

endmodule

`default_nettype wire

// File: tb/tb_ms_tick_ctrl.sv
// ============================================================================
// tb_ms_tick_ctrl : directed self-checking bench, DIV=10, DEB_CYC=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ms_tick_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       BTN_SS = 1'b0;
  logic       BTN_CLR = 1'b0;
  logic       TICK, CLR, RUNNING;
  logic [1:0] STATE;

  int n_chk = 0;
  int n_fail = 0;

  ms_tick_ctrl #(
    .CLK_HZ  (10000),
    .TICK_HZ (1000),
    .DEB_CYC (4)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .BTN_SS  (BTN_SS),
    .BTN_CLR (BTN_CLR),
    .TICK    (TICK),
    .CLR     (CLR),
    .RUNNING (RUNNING),
    .STATE   (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; outputs are then sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic step_count(input int n, output int ticks, output int clrs);
    ticks = 0;
    clrs  = 0;
    repeat (n) begin
      step(1);
      if (TICK === 1'b1) ticks++;
      if (CLR === 1'b1) clrs++;
    end
  endtask

  // Steps until TICK is seen; n is the edge count, or max+1 on timeout.
  task automatic wait_tick(input int max, output int n);
    n = 0;
    while (n <= max) begin
      step(1);
      n++;
      if (TICK === 1'b1) return;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c, n;

    // Reset
    step(3);
    check("rst_state", 32'(STATE), 32'd0);
    check("rst_tick", 32'(TICK), 32'd0);
    check("rst_clr", 32'(CLR), 32'd0);
    check("rst_running", 32'(RUNNING), 32'd0);
    RST_N = 1'b1;
    step_count(50, t, c);
    check("idle_ticks", 32'(t), 32'd0);
    check("idle_clrs", 32'(c), 32'd0);
    check("idle_state", 32'(STATE), 32'd0);

    // Start: STATE changes on the 7th edge after the raw level appears
    BTN_SS = 1'b1;
    step(6);
    check("start_pre", 32'(STATE), 32'd0);
    step(1);
    check("start_state", 32'(STATE), 32'd1);
    check("start_running", 32'(RUNNING), 32'd1);
    wait_tick(40, n);
    check("first_tick_dist", 32'(n), 32'd10);
    BTN_SS = 1'b0;
    step_count(50, t, c);
    check("tick_rate", 32'(t), 32'd5);
    check("tick_phase", 32'(TICK), 32'd1);

    // Pause with count=6 held, resume completes the remaining 4 cycles
    step(9);
    check("no_tick_mid", 32'(TICK), 32'd0);
    BTN_SS = 1'b1;
    step(1);
    check("tick_before_pause", 32'(TICK), 32'd1);
    step(5);
    check("pause_pre", 32'(STATE), 32'd1);
    step(1);
    check("pause_state", 32'(STATE), 32'd2);
    check("pause_running", 32'(RUNNING), 32'd0);
    BTN_SS = 1'b0;
    step_count(30, t, c);
    check("pause_ticks", 32'(t), 32'd0);
    check("pause_hold", 32'(STATE), 32'd2);
    BTN_SS = 1'b1;
    step(7);
    check("resume_state", 32'(STATE), 32'd1);
    BTN_SS = 1'b0;
    wait_tick(40, n);
    check("resume_remainder", 32'(n), 32'd4);

    // Glitchy button never stays stable for 4 samples
    step(10);
    BTN_SS = 1'b1; step(3);
    BTN_SS = 1'b0; step(1);
    BTN_SS = 1'b1; step(3);
    BTN_SS = 1'b0; step(12);
    check("glitch_state", 32'(STATE), 32'd1);
    check("glitch_running", 32'(RUNNING), 32'd1);

    // Simultaneous start/stop and clear: clear wins
    BTN_SS = 1'b1;
    BTN_CLR = 1'b1;
    step(6);
    check("clr_pre", 32'(STATE), 32'd1);
    step(1);
    check("clr_state", 32'(STATE), 32'd0);
    check("clr_pulse", 32'(CLR), 32'd1);
    check("clr_tick", 32'(TICK), 32'd0);
    check("clr_running", 32'(RUNNING), 32'd0);
    BTN_SS = 1'b0;
    BTN_CLR = 1'b0;
    step(1);
    check("clr_once", 32'(CLR), 32'd0);
    step(10);
    BTN_SS = 1'b1;
    step(7);
    check("restart_state", 32'(STATE), 32'd1);
    BTN_SS = 1'b0;
    wait_tick(40, n);
    check("restart_first_tick", 32'(n), 32'd10);

    // Reset mid-RUN with count=7
    step(7);
    RST_N = 1'b0;
    step(1);
    check("midrst_state", 32'(STATE), 32'd0);
    check("midrst_running", 32'(RUNNING), 32'd0);
    check("midrst_tick", 32'(TICK), 32'd0);
    check("midrst_clr", 32'(CLR), 32'd0);
    RST_N = 1'b1;
    step_count(30, t, c);
    check("post_rst_ticks", 32'(t), 32'd0);
    check("post_rst_clrs", 32'(c), 32'd0);
    check("post_rst_state", 32'(STATE), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
